idli_fetch_m: RTL and testbench

Instruction fetch front end. Drives an external SQI SRAM through its read protocol. Streams returned instruction nibbles, 4b per cycle, into the decoder's i_dcd_enc / i_dcd_enc_vld input, and tracks the word PC of the instruction being streamed. A redirect from the backend on a taken branch or jump aborts the current burst and restarts the read at the new PC.

---
 rtl/idli_fetch_m.sv | 126 ++++++++++++
 tb/tb_idli_fetch_m.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_fetch_m.sv
// Instruction fetch front end: issues SQI read bursts (cmd 0x03, 24b address, dummy
// turnaround) and streams the returned nibbles to the decoder with the word PC.
module idli_fetch_m #(
   parameter int          DUMMY_CYCLES = 2,
   parameter logic [15:0] RST_PC       = 16'h0000
) (
   input  logic        i_fch_gck,
   input  logic        i_fch_rst,
   input  logic        i_fch_redir,
   input  logic [15:0] i_fch_redir_pc,
   output logic        o_fch_sqi_cs_n,
   output logic [3:0]  o_fch_sqi_sio,
   output logic        o_fch_sqi_sio_oe,
   input  logic [3:0]  i_fch_sqi_sio,
   output logic [3:0]  o_fch_enc,
   output logic        o_fch_enc_vld,
   output logic [15:0] o_fch_pc
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

   state_t      r_state;
   logic [7:0]  r_cyc;
   logic [1:0]  r_nib;
   logic [15:0] r_pend_pc;
   logic [15:0] r_pc;
   logic [23:0] r_addr;
   logic        r_cs_n;
   logic        r_oe;
   logic [3:0]  r_sio;
   logic [3:0]  r_enc;
   logic        r_vld;
   logic        w_wrap;

   // The next load would belong to PC 0x10000; the memory stream would be at byte
   // 0x20000 instead of 0, so the burst is restarted at PC 0.
   assign w_wrap = (r_state == DATA) && r_vld && (r_nib == 2'd0) && (r_pc == 16'hFFFF);

   // NOTE: sequential state uses non-blocking assignments only, so every branch
   // below sees the pre-edge values of all registers.
   always_ff @(posedge i_fch_gck or posedge i_fch_rst) begin
      if (i_fch_rst) begin
         r_state   <= IDLE;
         r_cyc     <= 8'd0;
         r_nib     <= 2'd0;
         r_pend_pc <= RST_PC;
         r_pc      <= RST_PC;
         r_addr    <= 24'd0;
         r_cs_n    <= 1'b1;
         r_oe      <= 1'b0;
         r_sio     <= 4'h0;
         r_enc     <= 4'h0;
         r_vld     <= 1'b0;
      end else if (i_fch_redir || w_wrap) begin
         r_state   <= IDLE;
         r_cyc     <= 8'd0;
         r_nib     <= 2'd0;
         r_pend_pc <= i_fch_redir ? i_fch_redir_pc : 16'h0000;
         r_pc      <= i_fch_redir ? i_fch_redir_pc : 16'h0000;
         r_cs_n    <= 1'b1;
         r_oe      <= 1'b0;
         r_sio     <= 4'h0;
         r_vld     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_addr  <= {7'b0, r_pend_pc, 1'b0};
               r_pc    <= r_pend_pc;
               r_state <= CMD;
               r_cyc   <= 8'd0;
               r_cs_n  <= 1'b0;
               r_oe    <= 1'b1;
               r_sio   <= 4'h0;
            end
            CMD: begin
               if (r_cyc == 8'd0) begin
                  r_cyc <= 8'd1;
                  r_sio <= 4'h3;
               end else begin
                  r_cyc   <= 8'd0;
                  r_state <= ADDR;
                  r_sio   <= r_addr[23:20];
                  r_addr  <= {r_addr[19:0], 4'h0};
               end
            end
            ADDR: begin
               if (r_cyc == 8'd5) begin
                  r_cyc   <= 8'd0;
                  r_state <= DUMMY;
                  r_oe    <= 1'b0;
                  r_sio   <= 4'h0;
               end else begin
                  r_cyc  <= r_cyc + 8'd1;
                  r_sio  <= r_addr[23:20];
                  r_addr <= {r_addr[19:0], 4'h0};
               end
            end
            DUMMY: begin
               if (r_cyc == 8'(DUMMY_CYCLES - 1)) begin
                  r_cyc   <= 8'd0;
                  r_state <= DATA;
               end else begin
                  r_cyc <= r_cyc + 8'd1;
               end
            end
            DATA: begin
               // PC advances with the first nibble of every instruction but the burst's first.
               r_enc <= i_fch_sqi_sio;
               r_vld <= 1'b1;
               r_nib <= r_nib + 2'd1;
               if (r_vld && (r_nib == 2'd0))
                  r_pc <= r_pc + 16'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_fch_sqi_cs_n   = r_cs_n;
   assign o_fch_sqi_sio    = r_sio;
   assign o_fch_sqi_sio_oe = r_oe;
   assign o_fch_enc        = r_enc;
   assign o_fch_enc_vld    = r_vld;
   assign o_fch_pc         = r_pc;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: behavioural SQI memory plus an instruction-stream scoreboard
// driven by directed scenarios and random redirects.
module tb_idli_fetch_m;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam int          DUMMY  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redir = 1'b0;
   logic [15:0] redir_pc = 16'h0;
   logic [3:0]  mem_sio = 4'h0;
   logic        cs_n, oe, vld;
   logic [3:0]  sio, enc;
   logic [15:0] pc;
   logic        cs_n4, oe4, vld4;
   logic [3:0]  sio4, enc4;
   logic [15:0] pc4;

   idli_fetch_m #(.DUMMY_CYCLES(DUMMY), .RST_PC(RST_PC)) u_dut (
      .i_fch_gck(clk), .i_fch_rst(rst), .i_fch_redir(redir), .i_fch_redir_pc(redir_pc),
      .o_fch_sqi_cs_n(cs_n), .o_fch_sqi_sio(sio), .o_fch_sqi_sio_oe(oe),
      .i_fch_sqi_sio(mem_sio), .o_fch_enc(enc), .o_fch_enc_vld(vld), .o_fch_pc(pc));

   idli_fetch_m #(.DUMMY_CYCLES(4), .RST_PC(RST_PC)) u_dut4 (
      .i_fch_gck(clk), .i_fch_rst(rst), .i_fch_redir(1'b0), .i_fch_redir_pc(16'h0),
      .o_fch_sqi_cs_n(cs_n4), .o_fch_sqi_sio(sio4), .o_fch_sqi_sio_oe(oe4),
      .i_fch_sqi_sio(4'hA), .o_fch_enc(enc4), .o_fch_enc_vld(vld4), .o_fch_pc(pc4));

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_sb  = 0;
   logic [15:0] mem [65536];

   // Reference view: the instruction stream the decoder should see.
   logic [15:0] exp_pc = RST_PC;
   int          exp_nib = 0;
   logic [15:0] exp_burst = RST_PC;

   // Memory side: what the SQI device has received in the current burst.
   int          m_cnt = 0;
   logic [31:0] m_sh = 32'h0;
   int          m_bursts = 0;
   logic [23:0] m_last_addr = 24'h0;

   // Nibble idx of a big-endian byte stream starting at byte address baddr.
   function automatic logic [3:0] mem_nib(input logic [23:0] baddr, input int idx);
      logic [23:0] b;
      logic [22:0] w;
      logic [15:0] d;
      b = baddr + 24'(idx / 2);
      w = b[23:1];
      d = (w[22:16] == 7'd0) ? mem[w[15:0]] : (w[15:0] ^ 16'hA5A5);
      return 4'(d >> (4 * (3 - (idx % 4))));
   endfunction

   always @(negedge clk) begin
      if (rst || cs_n) begin
         m_cnt   = 0;
         mem_sio = 4'($urandom);
      end else begin
         m_cnt++;
         n_vec++;
         if (m_cnt <= 8) begin
            if (oe !== 1'b1) begin
               n_err++;
               $display("FAIL sqi_oe_header: burst cycle %0d oe=%b required 1", m_cnt, oe);
            end
            m_sh = {m_sh[27:0], sio};
         end else if (oe !== 1'b0) begin
            n_err++;
            $display("FAIL sqi_oe_turnaround: burst cycle %0d oe=%b required 0", m_cnt, oe);
         end
         if (m_cnt == 8) begin
            m_bursts++;
            m_last_addr = m_sh[23:0];
            n_vec++;
            if (m_sh !== {8'h03, 7'b0, exp_burst, 1'b0}) begin
               n_err++;
               $display("FAIL burst_header: got %h required %h", m_sh, {8'h03, 7'b0, exp_burst, 1'b0});
            end
         end
         mem_sio = (m_cnt > 8 + DUMMY) ? mem_nib(m_last_addr, m_cnt - 9 - DUMMY) : 4'($urandom);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         exp_pc    = RST_PC;
         exp_nib   = 0;
         exp_burst = RST_PC;
      end else if (vld === 1'b1) begin
         logic [3:0] e;
         e = 4'(mem[exp_pc] >> (4 * (3 - exp_nib)));
         n_vec++;
         n_sb++;
         if (enc !== e || pc !== exp_pc) begin
            n_err++;
            $display("FAIL stream: enc=%h pc=%h required enc=%h pc=%h", enc, pc, e, exp_pc);
         end
         exp_nib++;
         if (exp_nib == 4) begin
            exp_nib = 0;
            exp_pc++;
            if (exp_pc == 16'h0000) exp_burst = 16'h0000;
         end
      end
   end

   // Caller is between a negedge and the next posedge.
   task automatic pulse_redir(input logic [15:0] t);
      redir_pc  = t;
      redir     = 1'b1;
      exp_pc    = t;
      exp_nib   = 0;
      exp_burst = t;
      @(posedge clk);
      #1 redir = 1'b0;
   endtask

   task automatic wait_vld(input string tag, input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (vld !== 1'b1 && cyc < max);
      if (vld !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: no enc_vld within %0d cycles", tag, max);
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      n_vec++;
      if (cs_n !== 1'b1 || sio !== 4'h0 || oe !== 1'b0 || enc !== 4'h0 || vld !== 1'b0 || pc !== RST_PC) begin
         n_err++;
         $display("FAIL %s: cs_n=%b sio=%h oe=%b enc=%h vld=%b pc=%h required 1 0 0 0 0 %h",
                  tag, cs_n, sio, oe, enc, vld, pc, RST_PC);
      end
   endtask

   // Checks the 16 cycles after reset release; returns the first four nibbles and the PC on the 5th.
   task automatic run_startup(input string tag, output logic [15:0] word, output logic [15:0] pc5);
      logic [31:0] hdr;
      hdr = {8'h03, 7'b0, RST_PC, 1'b0};
      word = 16'h0;
      pc5 = 16'h0;
      release_rst();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         n_vec++;
         if (cs_n !== 1'b0 || vld !== (k >= 12)) begin
            n_err++;
            $display("FAIL %s_seq: cycle %0d cs_n=%b vld=%b required 0 %b", tag, k, cs_n, vld, k >= 12);
         end
         if (k <= 8) begin
            n_vec++;
            if (sio !== hdr[31 - 4 * (k - 1) -: 4]) begin
               n_err++;
               $display("FAIL %s_sio: cycle %0d sio=%h required %h", tag, k, sio, hdr[31 - 4 * (k - 1) -: 4]);
            end
         end
         if (k >= 12 && k <= 15) word = {word[11:0], enc};
         if (k == 16) pc5 = pc;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("reset_values");
   endtask

   task automatic test_first_fetch();
      logic [15:0] w, p;
      run_startup("first_fetch", w, p);
      n_vec++;
      if (w !== 16'hC123 || p !== RST_PC + 16'd1) begin
         n_err++;
         $display("FAIL first_fetch_data: nibbles=%h pc5=%h required c123 %h", w, p, RST_PC + 16'd1);
      end
   endtask

   task automatic test_redirect_data();
      logic [31:0] hdr;
      int          c;
      hdr = {8'h03, 24'h002468};
      rst = 1'b1;
      release_rst();
      repeat (13) @(negedge clk);
      #1 pulse_redir(16'h1234);
      @(negedge clk);
      n_vec++;
      if (vld !== 1'b0 || cs_n !== 1'b1) begin
         n_err++;
         $display("FAIL redir_abort: vld=%b cs_n=%b required 0 1", vld, cs_n);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_vec++;
         if (cs_n !== 1'b0 || sio !== hdr[31 - 4 * k -: 4]) begin
            n_err++;
            $display("FAIL redir_hdr: nibble %0d cs_n=%b sio=%h required 0 %h", k, cs_n, sio, hdr[31 - 4 * k -: 4]);
         end
      end
      wait_vld("redir_data", 10, c);
      n_vec++;
      if (pc !== 16'h1234 || c != 4) begin
         n_err++;
         $display("FAIL redir_resume: pc=%h wait=%0d required 1234 4", pc, c);
      end
   endtask

   task automatic test_back_to_back();
      int b0, c;
      rst = 1'b1;
      release_rst();
      repeat (5) @(negedge clk);
      b0 = m_bursts;
      #1 pulse_redir(16'h0040);
      pulse_redir(16'h0080);
      wait_vld("b2b", 30, c);
      n_vec++;
      if (m_bursts !== b0 + 1 || m_last_addr !== 24'h000100 || pc !== 16'h0080) begin
         n_err++;
         $display("FAIL back_to_back: bursts=%0d addr=%h pc=%h required %0d 000100 0080",
                  m_bursts - b0, m_last_addr, pc, 1);
      end
   endtask

   task automatic test_pc_wrap();
      int c, hi, spur;
      @(negedge clk);
      #1 pulse_redir(16'hFFFF);
      wait_vld("wrap_start", 30, c);
      repeat (3) @(negedge clk);
      n_vec++;
      if (pc !== 16'hFFFF || vld !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_last: pc=%h vld=%b required ffff 1", pc, vld);
      end
      hi = 0;
      spur = 0;
      c = 0;
      do begin
         @(negedge clk);
         c++;
         if (cs_n === 1'b1) hi++;
      end while (vld !== 1'b1 && c < 20);
      n_vec++;
      if (c != 13 || hi != 1 || pc !== 16'h0000 || m_last_addr !== 24'h0) begin
         n_err++;
         $display("FAIL wrap_restart: gap=%0d cs_hi=%0d pc=%h addr=%h required 13 1 0000 000000",
                  c, hi, pc, m_last_addr);
      end
      if (spur != 0) $display("unreachable");
   endtask

   task automatic test_reset_mid(input int cyc, input string tag);
      logic [15:0] w, p;
      rst = 1'b1;
      release_rst();
      repeat (cyc) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals(tag);
      repeat (2) @(negedge clk);
      run_startup(tag, w, p);
      n_vec++;
      if (w !== mem[RST_PC]) begin
         n_err++;
         $display("FAIL %s_data: nibbles=%h required %h", tag, w, mem[RST_PC]);
      end
   endtask

   task automatic test_dummy_cycles();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      release_rst();
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         n_vec++;
         if (cs_n4 !== 1'b0 || vld4 !== (k == 14) || oe4 !== (k <= 8)) begin
            n_err++;
            $display("FAIL dummy4: cycle %0d cs_n=%b vld=%b oe=%b required 0 %b %b",
                     k, cs_n4, vld4, oe4, k == 14, k <= 8);
         end
      end
      n_vec++;
      if (enc4 !== 4'hA || pc4 !== RST_PC) begin
         n_err++;
         $display("FAIL dummy4_data: enc=%h pc=%h required a %h", enc4, pc4, RST_PC);
      end
   endtask

   task automatic test_random_redirects();
      int          sb0;
      logic [15:0] t;
      sb0 = n_sb;
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         t = 16'($urandom);
         if ($urandom_range(0, 3) == 0) t = 16'hFFFE + 16'($urandom_range(0, 1));
         #1 pulse_redir(t);
         if ($urandom_range(0, 3) == 0) pulse_redir(16'($urandom));
      end
      repeat (40) @(negedge clk);
      n_vec++;
      if (n_sb - sb0 < 50) begin
         n_err++;
         $display("FAIL random_activity: %0d nibbles checked required >= 50", n_sb - sb0);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'hC123;
      test_reset();
      test_first_fetch();
      test_redirect_data();
      test_back_to_back();
      test_pc_wrap();
      test_reset_mid(9, "reset_dummy");
      test_reset_mid(14, "reset_data");
      test_dummy_cycles();
      test_random_redirects();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
